dcache_wb_burst_tx: RTL and testbench

Writeback transmitter for the L1 data cache. It takes a full 256-bit dirty line read out of the dcache data array and sends it to physical memory as a fixed-length burst of 64-bit beats. It sits between the dcache controller (request side) and the cacheline/pmem interface (burst side). It is the read-out counterpart to the byte-masked line write path into the data array.

---
 rtl/dcache_wb_burst_tx.sv | 85 ++++++++
 tb/tb_dcache_wb_burst_tx.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/dcache_wb_burst_tx.sv
// rtl/dcache_wb_burst_tx.sv - dirty-line writeback burst transmitter
module dcache_wb_burst_tx #(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64,
  parameter int BEATS      = LINE_WIDTH / BEAT_WIDTH,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [LINE_WIDTH-1:0] line_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  wb_done,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [BEAT_WIDTH-1:0] pmem_wdata,
  input  logic                  pmem_resp
);

  localparam int BW          = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
  localparam logic [BW-1:0]         LAST_BEAT = BW'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'((1 << OFFSET_BITS) - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BURST = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]            state;
  logic [BW-1:0]         beat;
  logic [LINE_WIDTH-1:0] line_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BEAT_WIDTH-1:0] beat_data [BEATS];

  for (genvar g = 0; g < BEATS; g++) begin : g_beat
    assign beat_data[g] = line_q[g*BEAT_WIDTH +: BEAT_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      beat   <= '0;
      line_q <= '0;
      addr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wb_valid) begin
            line_q <= line_i;
            addr_q <= addr_i & LINE_MASK;
            beat   <= '0;
            state  <= BURST;
          end
        end
        BURST: begin
          // A stalled beat (no resp) keeps beat and state, so outputs hold.
          if (pmem_resp) begin
            if (beat == LAST_BEAT) begin
              state <= DONE;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          beat  <= '0;
        end
        default: begin
          state <= IDLE;
          beat  <= '0;
        end
      endcase
    end
  end

  // Outputs decode registered state only; nothing flows through from inputs.
  assign wb_ready     = (state == IDLE);
  assign wb_done      = (state == DONE);
  assign pmem_write   = (state == BURST);
  assign pmem_address = pmem_write ? addr_q : '0;
  assign pmem_wdata   = pmem_write ? beat_data[beat] : '0;

endmodule

// File: tb/tb_dcache_wb_burst_tx.sv
// tb/tb_dcache_wb_burst_tx.sv - self-checking bench for dcache_wb_burst_tx
module tb_dcache_wb_burst_tx;

  logic         clk = 1'b0;
  logic         rst;
  logic         wb_valid;
  logic         wb_ready;
  logic [255:0] line_i;
  logic [31:0]  addr_i;
  logic         wb_done;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [63:0]  pmem_wdata;
  logic         pmem_resp;

  int n_cmp = 0;
  int n_err = 0;

  dcache_wb_burst_tx dut (
    .clk          (clk),
    .rst          (rst),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .line_i       (line_i),
    .addr_i       (addr_i),
    .wb_done      (wb_done),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
      $error("%s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Reference: beat k is line >> 64k; one beat retires per resp; done one cycle after the 4th resp.
  task automatic do_burst(input logic [255:0] line, input logic [31:0] addr,
                          input int period, input bit corrupt, input bit hold);
    int           k;
    int           cyc;
    bit           r;
    logic [255:0] sh;
    logic [31:0]  exp_addr;
    exp_addr = addr & 32'hFFFF_FFE0;
    chk("idle_ready", 64'(wb_ready), 64'd1);
    wb_valid  = 1'b1;
    line_i    = line;
    addr_i    = addr;
    pmem_resp = 1'($urandom % 2);
    @(negedge clk);
    if (!hold) wb_valid = 1'b0;
    if (corrupt) begin
      line_i = '1;
      addr_i = '1;
    end
    k   = 0;
    cyc = 0;
    while (k < 4 && cyc < 100) begin
      sh = line >> (64 * k);
      chk("burst_write", 64'(pmem_write), 64'd1);
      chk("burst_ready", 64'(wb_ready), 64'd0);
      chk("burst_done",  64'(wb_done), 64'd0);
      chk("burst_addr",  64'(pmem_address), 64'(exp_addr));
      chk("burst_wdata", pmem_wdata, sh[63:0]);
      r = ((cyc % period) == period - 1);
      pmem_resp = r;
      @(negedge clk);
      if (r) k++;
      cyc++;
    end
    chk("burst_beats", 64'(k), 64'd4);
    pmem_resp = 1'($urandom % 2);
    chk("done_pulse", 64'(wb_done), 64'd1);
    chk("done_write", 64'(pmem_write), 64'd0);
    chk("done_ready", 64'(wb_ready), 64'd0);
    chk("done_wdata", pmem_wdata, 64'd0);
    @(negedge clk);
    chk("post_ready", 64'(wb_ready), 64'd1);
    chk("post_done",  64'(wb_done), 64'd0);
    chk("post_write", 64'(pmem_write), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] basic;
    basic = 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111;

    rst = 1'b1; wb_valid = 1'b0; line_i = '0; addr_i = '0; pmem_resp = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready",   64'(wb_ready), 64'd1);
    chk("rst_write",   64'(pmem_write), 64'd0);
    chk("rst_done",    64'(wb_done), 64'd0);
    chk("rst_address", 64'(pmem_address), 64'd0);
    chk("rst_wdata",   pmem_wdata, 64'd0);

    for (int i = 0; i < 4; i++) begin
      pmem_resp = 1'(i % 2);
      @(negedge clk);
      chk("idle_resp_ready", 64'(wb_ready), 64'd1);
      chk("idle_resp_write", 64'(pmem_write), 64'd0);
      chk("idle_resp_done",  64'(wb_done), 64'd0);
    end

    do_burst(basic, 32'h0000_1234, 1, 1'b0, 1'b0);
    do_burst(basic, 32'h0000_1234, 3, 1'b0, 1'b0);
    do_burst(basic, 32'h0000_1234, 1, 1'b1, 1'b0);

    do_burst(rand_line(), 32'h0000_0100, 1, 1'b0, 1'b1);
    do_burst(rand_line(), 32'h0000_0200, 1, 1'b0, 1'b0);

    wb_valid = 1'b1; line_i = basic; addr_i = 32'h0000_4040; pmem_resp = 1'b1;
    @(negedge clk);
    wb_valid = 1'b0;
    chk("mid_beat0", pmem_wdata, 64'h1111111111111111);
    @(negedge clk);
    chk("mid_beat1", pmem_wdata, 64'h2222222222222222);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; pmem_resp = 1'b0;
    chk("mid_rst_write", 64'(pmem_write), 64'd0);
    chk("mid_rst_ready", 64'(wb_ready), 64'd1);
    chk("mid_rst_done",  64'(wb_done), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_no_done", 64'(wb_done), 64'd0);
    end
    do_burst(rand_line(), 32'h0000_8000, 1, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      do_burst(rand_line(), $urandom, 1 + int'($urandom % 3),
               1'($urandom % 2), 1'($urandom % 2));
    end
    wb_valid = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
